// File: rtl/debounce_pkg.sv
// Shared encodings and defaults for the pad-input debounce path.
// State bit 1 equals the debounced level, so the encoding is not arbitrary.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 50000;  // 1 ms at 50 MHz
  localparam int DEF_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/PNU_DFF.sv
// Plain D flip-flop with synchronous active-high clear.
module PNU_DFF (
  input  logic clock,
  input  logic reset,
  input  logic D,
  output logic Q
);

  always_ff @(posedge clock) begin
    if (reset) Q <= 1'b0;
    else       Q <= D;
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for an asynchronous pad input; reusable for any pad.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic D,
  output logic Q
);

  logic s1;

  PNU_DFF u_s1 (.clock(clock), .reset(reset), .D(D),  .Q(s1));
  PNU_DFF u_s2 (.clock(clock), .reset(reset), .D(s1), .Q(Q));

endmodule

// File: rtl/debounce_filter.sv
// Synchronise a bouncy pad input and accept a new level only after
// STABLE_CYCLES consecutive agreeing samples.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_2ff u_sync (.clock(clock), .reset(reset), .D(raw), .Q(s2));

  // Entering WAIT already counts the first agreeing sample, hence cnt=1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE_LOW: begin
          if (s2) begin
            state <= ST_WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s2) begin
            state <= ST_IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        ST_IDLE_HIGH: begin
          if (!s2) begin
            state <= ST_WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s2) begin
            state <= ST_IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
